// File: rtl/lock_sequencer_if.sv
// Control/status bundle between the servo controller and a lock_sequencer.
// master drives configuration and inputs; slave is the sequencer itself.
interface lock_sequencer_if #(
    parameter int SIGNAL_SIZE = 25,
    parameter int CNT_W       = 24
);
    logic                          enable;
    logic                          hold_req;
    logic signed [SIGNAL_SIZE-1:0] s_err;
    logic signed [SIGNAL_SIZE-1:0] s_I;
    logic signed [SIGNAL_SIZE-1:0] LL;
    logic signed [SIGNAL_SIZE-1:0] UL;
    logic        [SIGNAL_SIZE-2:0] margin;
    logic        [SIGNAL_SIZE-2:0] err_thresh;
    logic        [SIGNAL_SIZE-2:0] sweep_step;
    logic        [CNT_W-1:0]       N_lock;
    logic        [CNT_W-1:0]       N_rail;
    logic                          on;
    logic                          hold;
    logic                          locked;
    logic signed [SIGNAL_SIZE-1:0] sweep_out;
    logic        [7:0]             relock_count;
    logic        [2:0]             state;

    modport master (
        output enable, hold_req, s_err, s_I, LL, UL, margin, err_thresh,
               sweep_step, N_lock, N_rail,
        input  on, hold, locked, sweep_out, relock_count, state
    );

    modport slave (
        input  enable, hold_req, s_err, s_I, LL, UL, margin, err_thresh,
               sweep_step, N_lock, N_rail,
        output on, hold, locked, sweep_out, relock_count, state
    );
endinterface

// File: rtl/lock_sequencer.sv
// Lock-acquisition / relock controller for one servo integrator: sweeps an
// offset into the capture window, qualifies lock, and clears on rail contact.
//
// state   | meaning
// IDLE    | disabled; integrator off, sweep at 0, direction up
// SWEEP   | integrator off; offset ramps between LL and UL until error in window
// ACQUIRE | integrator on; counting consecutive in-window samples
// LOCKED  | lock declared; hold follows hold_req; watching for rail dwell
// CLEAR   | integrator off for CLR_CYC cycles, then resweep in reverse
module lock_sequencer #(
    parameter int SIGNAL_SIZE = 25,
    parameter int CNT_W       = 24,
    parameter int CLR_CYC     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    lock_sequencer_if.slave bus
);
    localparam int SW = SIGNAL_SIZE + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SWEEP   = 3'd1,
        S_ACQUIRE = 3'd2,
        S_LOCKED  = 3'd3,
        S_CLEAR   = 3'd4
    } state_t;

    logic                          r_enable;
    logic signed [SIGNAL_SIZE-1:0] r_s_err;
    logic signed [SIGNAL_SIZE-1:0] r_s_I;
    logic signed [SIGNAL_SIZE-1:0] r_LL;
    logic signed [SIGNAL_SIZE-1:0] r_UL;
    logic        [SIGNAL_SIZE-2:0] r_margin;
    logic        [SIGNAL_SIZE-2:0] r_err_thresh;
    logic        [SIGNAL_SIZE-2:0] r_sweep_step;
    logic        [CNT_W-1:0]       r_N_lock;
    logic        [CNT_W-1:0]       r_N_rail;

    state_t                        r_state;
    logic        [CNT_W-1:0]       r_cnt;
    logic        [CNT_W-1:0]       r_rail_cnt;
    logic signed [SIGNAL_SIZE-1:0] r_sweep;
    logic                          r_dir_up;
    logic        [7:0]             r_relock;
    logic                          r_on;
    logic                          r_hold;
    logic                          r_locked;

    state_t                        w_state_nxt;
    logic        [CNT_W-1:0]       w_cnt_nxt;
    logic        [CNT_W-1:0]       w_rail_nxt;
    logic signed [SIGNAL_SIZE-1:0] w_sweep_nxt;
    logic                          w_dir_nxt;
    logic        [7:0]             w_relock_nxt;
    logic                          w_on_nxt;
    logic                          w_hold_nxt;
    logic                          w_locked_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable     <= 1'b0;
            r_s_err      <= '0;
            r_s_I        <= '0;
            r_LL         <= '0;
            r_UL         <= '0;
            r_margin     <= '0;
            r_err_thresh <= '0;
            r_sweep_step <= '0;
            r_N_lock     <= '0;
            r_N_rail     <= '0;
        end else begin
            r_enable     <= bus.enable;
            r_s_err      <= bus.s_err;
            r_s_I        <= bus.s_I;
            r_LL         <= bus.LL;
            r_UL         <= bus.UL;
            r_margin     <= bus.margin;
            r_err_thresh <= bus.err_thresh;
            r_sweep_step <= bus.sweep_step;
            r_N_lock     <= bus.N_lock;
            r_N_rail     <= bus.N_rail;
        end
    end

    // All window/rail arithmetic is one bit wider so nothing wraps.
    logic signed [SW-1:0] w_err_ext;
    logic        [SW-1:0] w_err_abs;
    logic                 w_inwin;
    logic signed [SW-1:0] w_si_ext;
    logic signed [SW-1:0] w_ul_ext;
    logic signed [SW-1:0] w_ll_ext;
    logic signed [SW-1:0] w_margin_ext;
    logic                 w_rail;

    assign w_err_ext    = {r_s_err[SIGNAL_SIZE-1], r_s_err};
    assign w_err_abs    = w_err_ext[SW-1] ? $unsigned(-w_err_ext) : $unsigned(w_err_ext);
    assign w_inwin      = (w_err_abs <= {2'b00, r_err_thresh});
    assign w_si_ext     = {r_s_I[SIGNAL_SIZE-1], r_s_I};
    assign w_ul_ext     = {r_UL[SIGNAL_SIZE-1], r_UL};
    assign w_ll_ext     = {r_LL[SIGNAL_SIZE-1], r_LL};
    assign w_margin_ext = {2'b00, r_margin};
    assign w_rail       = (w_si_ext >= (w_ul_ext - w_margin_ext)) ||
                          (w_si_ext <= (w_ll_ext + w_margin_ext));

    logic signed [SW-1:0]          w_sweep_ext;
    logic signed [SW-1:0]          w_step_ext;
    logic signed [SW-1:0]          w_sum;
    logic signed [SIGNAL_SIZE-1:0] w_sweep_clamp;
    logic                          w_dir_clamp;

    assign w_sweep_ext = {r_sweep[SIGNAL_SIZE-1], r_sweep};
    assign w_step_ext  = {2'b00, r_sweep_step};
    assign w_sum       = r_dir_up ? (w_sweep_ext + w_step_ext) : (w_sweep_ext - w_step_ext);

    always_comb begin
        w_sweep_clamp = w_sum[SIGNAL_SIZE-1:0];
        w_dir_clamp   = r_dir_up;
        if (w_sum >= w_ul_ext) begin
            w_sweep_clamp = r_UL;
            w_dir_clamp   = 1'b0;
        end else if (w_sum <= w_ll_ext) begin
            w_sweep_clamp = r_LL;
            w_dir_clamp   = 1'b1;
        end
    end

    // Dwell limits of zero behave as one.
    logic [CNT_W:0] w_cnt_inc;
    logic [CNT_W:0] w_rail_inc;
    logic [CNT_W:0] w_n_lock_eff;
    logic [CNT_W:0] w_n_rail_eff;
    logic           w_rail_done;
    logic           w_lock_done;

    assign w_cnt_inc    = {1'b0, r_cnt} + 1'b1;
    assign w_rail_inc   = {1'b0, r_rail_cnt} + 1'b1;
    assign w_n_lock_eff = (r_N_lock == '0) ? (CNT_W+1)'(1) : {1'b0, r_N_lock};
    assign w_n_rail_eff = (r_N_rail == '0) ? (CNT_W+1)'(1) : {1'b0, r_N_rail};
    assign w_rail_done  = w_rail && (w_rail_inc >= w_n_rail_eff);
    assign w_lock_done  = w_inwin && (w_cnt_inc >= w_n_lock_eff);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rail_nxt  = r_rail_cnt;
        w_sweep_nxt = r_sweep;
        w_dir_nxt   = r_dir_up;
        case (r_state)
            S_IDLE: begin
                w_sweep_nxt = '0;
                w_dir_nxt   = 1'b1;
                if (r_enable) w_state_nxt = S_SWEEP;
            end
            S_SWEEP: begin
                if (w_inwin) begin
                    w_state_nxt = S_ACQUIRE;
                end else begin
                    w_sweep_nxt = w_sweep_clamp;
                    w_dir_nxt   = w_dir_clamp;
                end
            end
            S_ACQUIRE: begin
                w_cnt_nxt  = w_inwin ? w_cnt_inc[CNT_W-1:0] : '0;
                w_rail_nxt = w_rail ? w_rail_inc[CNT_W-1:0] : '0;
                if (w_rail_done)      w_state_nxt = S_CLEAR;
                else if (w_lock_done) w_state_nxt = S_LOCKED;
            end
            S_LOCKED: begin
                w_rail_nxt = w_rail ? w_rail_inc[CNT_W-1:0] : '0;
                if (w_rail_done) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                if (w_cnt_inc >= (CNT_W+1)'(CLR_CYC)) begin
                    w_state_nxt = S_SWEEP;
                    w_dir_nxt   = ~r_dir_up;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (!r_enable) begin
            w_state_nxt = S_IDLE;
            w_sweep_nxt = '0;
            w_dir_nxt   = 1'b1;
        end
        if (w_state_nxt != r_state) begin
            w_cnt_nxt  = '0;
            w_rail_nxt = '0;
        end

        w_relock_nxt = r_relock;
        if ((w_state_nxt == S_CLEAR) && (r_state != S_CLEAR) && (r_relock != 8'hFF))
            w_relock_nxt = r_relock + 8'd1;

        // hold_req goes straight into the output flop for one cycle of latency.
        w_on_nxt     = (w_state_nxt == S_ACQUIRE) || (w_state_nxt == S_LOCKED);
        w_locked_nxt = (w_state_nxt == S_LOCKED);
        w_hold_nxt   = (w_state_nxt == S_LOCKED) && bus.hold_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rail_cnt <= '0;
            r_sweep    <= '0;
            r_dir_up   <= 1'b1;
            r_relock   <= '0;
            r_on       <= 1'b0;
            r_hold     <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rail_cnt <= w_rail_nxt;
            r_sweep    <= w_sweep_nxt;
            r_dir_up   <= w_dir_nxt;
            r_relock   <= w_relock_nxt;
            r_on       <= w_on_nxt;
            r_hold     <= w_hold_nxt;
            r_locked   <= w_locked_nxt;
        end
    end

    assign bus.on           = r_on;
    assign bus.hold         = r_hold;
    assign bus.locked       = r_locked;
    assign bus.sweep_out    = r_sweep;
    assign bus.relock_count = r_relock;
    assign bus.state        = r_state;
endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: capture, hold, chatter, rail loss,
// sweep clamping, abort, relock saturation and asynchronous reset.
module tb_lock_sequencer;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_clr;
    int   sweep_tbl [13] = '{300, 600, 900, 1000, 700, 400, 100,
                             -200, -500, -800, -1000, -700, -400};

    lock_sequencer_if #(.SIGNAL_SIZE(25), .CNT_W(24)) bus ();

    lock_sequencer #(.SIGNAL_SIZE(25), .CNT_W(24), .CLR_CYC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit);
        int k = 0;
        while (bus.state !== s && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_state", bus.state, s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.hold_req   = 1'b1;
        bus.s_err      = 25'sd10000;
        bus.s_I        = '0;
        bus.LL         = -25'sd1000;
        bus.UL         = 25'sd1000;
        bus.margin     = 24'd10;
        bus.err_thresh = 24'd5;
        bus.sweep_step = 24'd10;
        bus.N_lock     = 24'd8;
        bus.N_rail     = 24'd16;
        step(3);
        check_eq("rst_state", bus.state, 0);
        check_eq("rst_on", bus.on, 0);
        check_eq("rst_hold", bus.hold, 0);
        check_eq("rst_locked", bus.locked, 0);
        check_eq("rst_sweep", bus.sweep_out, 0);
        check_eq("rst_relock", bus.relock_count, 0);
        rst_n = 1'b1;
        step(2);
        check_eq("idle_stays", bus.state, 0);

        // Capture: error enters window 20 cycles after enable.
        bus.enable = 1'b1;
        step(2);
        check_eq("sweep_entry_state", bus.state, 1);
        check_eq("sweep_entry_val", bus.sweep_out, 0);
        check_eq("sweep_hold_blocked", bus.hold, 0);
        step(18);
        check_eq("sweep_ramp", bus.sweep_out, 180);
        bus.s_err = '0;
        step(1);
        check_eq("cap_lag_state", bus.state, 1);
        check_eq("cap_lag_on", bus.on, 0);
        check_eq("cap_lag_sweep", bus.sweep_out, 190);
        step(1);
        check_eq("acq_state", bus.state, 2);
        check_eq("acq_on", bus.on, 1);
        check_eq("acq_hold", bus.hold, 0);
        check_eq("acq_sweep_frozen", bus.sweep_out, 190);
        step(7);
        check_eq("acq_not_yet_locked", bus.locked, 0);
        step(1);
        check_eq("lock_flag", bus.locked, 1);
        check_eq("lock_state", bus.state, 3);
        check_eq("lock_sweep_frozen", bus.sweep_out, 190);
        check_eq("lock_hold_on", bus.hold, 1);

        // Hold pass-through in LOCKED.
        bus.hold_req = 1'b0;
        step(1);
        check_eq("hold_follow_0", bus.hold, 0);
        bus.hold_req = 1'b1;
        step(1);
        check_eq("hold_follow_1", bus.hold, 1);
        bus.hold_req = 1'b0;
        step(1);

        // Rail chatter: runs of 10 never reach N_rail=16.
        for (int i = 0; i < 6; i++) begin
            bus.s_I = (i % 2 == 0) ? 25'sd995 : 25'sd0;
            step(10);
            check_eq("chatter_locked", bus.locked, 1);
        end
        step(3);

        // Rail loss: 16 consecutive rail samples.
        bus.s_I   = 25'sd995;
        bus.s_err = 25'sd10000;
        step(16);
        check_eq("rail_pre_state", bus.state, 3);
        step(1);
        check_eq("clear_state", bus.state, 4);
        check_eq("clear_on", bus.on, 0);
        check_eq("clear_locked", bus.locked, 0);
        check_eq("clear_relock", bus.relock_count, 1);
        check_eq("clear_sweep_hold", bus.sweep_out, 190);
        n_clr = 0;
        while (bus.state == 3'd4 && n_clr < 20) begin
            n_clr++;
            @(negedge clk);
        end
        check_eq("clear_len", n_clr, 4);
        check_eq("resweep_state", bus.state, 1);
        check_eq("resweep_on", bus.on, 0);
        step(1);
        check_eq("resweep_reversed", bus.sweep_out, 180);

        // Abort from ACQUIRE.
        bus.s_err = '0;
        bus.s_I   = '0;
        step(2);
        check_eq("abort_acq_state", bus.state, 2);
        check_eq("abort_acq_sweep", bus.sweep_out, 170);
        bus.enable = 1'b0;
        step(2);
        check_eq("abort_state", bus.state, 0);
        check_eq("abort_sweep", bus.sweep_out, 0);
        check_eq("abort_on", bus.on, 0);
        check_eq("abort_relock_kept", bus.relock_count, 1);

        // Sweep clamping at both rails.
        bus.s_err      = 25'sd10000;
        bus.sweep_step = 24'd300;
        bus.enable     = 1'b1;
        step(2);
        check_eq("wrap_start", bus.sweep_out, 0);
        for (int i = 0; i < 13; i++) begin
            step(1);
            check_eq($sformatf("wrap_%0d", i), bus.sweep_out, sweep_tbl[i]);
        end

        // Repeated relock with N_rail=0 (acts as 1) saturates the counter.
        bus.s_err  = '0;
        bus.s_I    = 25'sd995;
        bus.N_rail = '0;
        bus.N_lock = 24'd100;
        step(2500);
        check_eq("relock_sat", bus.relock_count, 255);
        wait_state(3'd4, 20);
        check_eq("sat_clear_on", bus.on, 0);

        // Asynchronous reset mid-CLEAR, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_state", bus.state, 0);
        check_eq("arst_on", bus.on, 0);
        check_eq("arst_hold", bus.hold, 0);
        check_eq("arst_locked", bus.locked, 0);
        check_eq("arst_sweep", bus.sweep_out, 0);
        check_eq("arst_relock", bus.relock_count, 0);
        step(2);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Lock-acquisition and relock controller that drives the `on`/`hold` controls of the servo integrator and watches its error input and output. It sweeps an offset until the error enters a capture window, then enables the integrator and declares lock after a qualification period. It monitors the integrator output for rail contact and runs a clear-and-resweep cycle on loss of lock. It sits beside each I-filter instance in the servo chain; its `sweep_out` sums into the actuator path ahead of the output limiter.

## Interface

Parameters:
- SIGNAL_SIZE, 25, signal width, matching the servo filters
- CNT_W, 24, width of the dwell counters
- CLR_CYC, 4, number of cycles `on` is held low during CLEAR; must be ≥ integrator pipeline depth

Ports:
- clk  in  1  system clock, 100 MS/s
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 0 forces IDLE
- hold_req  in  1  external hold request; honoured only in LOCKED
- s_err  in  SIGNAL_SIZE signed  error signal (filter input)
- s_I  in  SIGNAL_SIZE signed  integrator output
- LL, UL  in  SIGNAL_SIZE signed  rails; LL < UL required
- margin  in  SIGNAL_SIZE-1 unsigned  rail-detect margin
- err_thresh  in  SIGNAL_SIZE-1 unsigned  capture window half-width
- sweep_step  in  SIGNAL_SIZE-1 unsigned  sweep increment per cycle
- N_lock, N_rail  in  CNT_W unsigned  qualification and unlock dwell counts
- on, hold  out  1  integrator controls
- locked  out  1  lock flag
- sweep_out  out  SIGNAL_SIZE signed  sweep offset
- relock_count  out  8 unsigned  saturating count of CLEAR entries
- state  out  3  current state code, for debug

## Operation

- State codes: IDLE=0, SWEEP=1, ACQUIRE=2, LOCKED=3, CLEAR=4.
- The following conditions are evaluated every cycle on registered inputs:
  - inwin = |s_err| ≤ err_thresh. |s_err| is computed in SIGNAL_SIZE+1 bits, so the most-negative input gives a positive magnitude.
  - rail = (s_I ≥ UL−margin) or (s_I ≤ LL+margin), computed in SIGNAL_SIZE+1 bits with no wrap.
- IDLE:
  - Outputs: on=0, hold=0, locked=0, sweep_out=0, direction=up.
  - enable=1 → SWEEP.
- SWEEP:
  - on=0.
  - sweep_out += sweep_step when the direction is up, −= when down. The sum is computed in SIGNAL_SIZE+1 bits.
  - If the result is ≥ UL, it clamps to UL and the direction becomes down. If the result is ≤ LL, it clamps to LL and the direction becomes up.
  - sweep_step=0 freezes the sweep.
  - inwin → ACQUIRE, with sweep_out frozen at its current value.
- ACQUIRE:
  - on=1, hold=0.
  - Counter cnt increments while inwin and clears to 0 on any !inwin.
  - cnt reaches N_lock → LOCKED.
  - rail for N_rail consecutive cycles → CLEAR.
- LOCKED:
  - on=1, locked=1, hold=hold_req.
  - Rail counter increments while rail and clears on !rail. Counting continues while hold=1.
  - Counter reaches N_rail → CLEAR.
- CLEAR:
  - on=0, hold=0, locked=0, sweep_out holds.
  - relock_count increments once on entry and saturates at 255.
  - After CLR_CYC cycles → SWEEP, with the direction reversed.
- enable=0 in any state → IDLE on the next edge. relock_count is preserved.
- N_lock=0 or N_rail=0 is treated as 1.
- Every counter clears on each state transition.

## Timing

- Reset values: state=IDLE, on=0, hold=0, locked=0, sweep_out=0, relock_count=0, all counters 0.
- Reset is asynchronous on assertion and synchronous on release.
- All outputs are registered; no combinational path runs from input to output.
- Inputs are registered once. A condition is therefore acted upon 2 edges after it appears at the ports.
- ACQUIRE→LOCKED occurs on the edge at which the N_lock-th consecutive registered inwin sample is counted.
- Simultaneous rail-dwell completion and N_lock completion in ACQUIRE resolve to CLEAR.
- Simultaneous enable=0 and any other transition resolve to IDLE.
- Reset mid-CLEAR or mid-LOCKED returns to IDLE with on=0 immediately, asynchronously.

## Test plan

- Capture: LL=−1000, UL=1000, step=10, s_err=0 after 20 cycles from enable, err_thresh=5, N_lock=8 → on=1 2 cycles after s_err enters the window; locked=1 8 cycles later; sweep_out frozen at its capture value.
- Sweep wrap: s_err=10000 constant, step=300 → sweep_out runs 0, 300, 600, 900, 1000 (clamped), 700, …, −1000 (clamped), −700, with no overshoot of either rail.
- Rail loss: locked, then s_I=995 with margin=10 for N_rail=16 cycles → CLEAR entered on count 16; on=0 for exactly 4 cycles; relock_count=1; SWEEP resumes with the direction reversed.
- Rail chatter: s_I alternates between 995 and 0 every 10 cycles, N_rail=16 → no CLEAR; locked stays 1.
- Hold pass-through: hold_req=1 in SWEEP gives hold=0; in LOCKED, hold follows hold_req with 1 cycle of latency.
- Abort/reset: enable=0 during ACQUIRE → IDLE next edge, sweep_out=0. rst_n low mid-CLEAR → all outputs return to reset values without a clock edge.
